// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, optional two's-complement
// mode, divide-by-zero reporting. Produces quotient (LO) and remainder (HI).
module seq_divider #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             Clear,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvsr_r;
  logic [CNT_W-1:0] cnt_r;
  logic             q_neg_r;
  logic             r_neg_r;
  logic             dz_r;

  logic             sgn_op;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             borrow;

  // Magnitude of a possibly-signed operand; MIN maps to itself, which reads
  // correctly as the unsigned magnitude 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    logic signed [WIDTH-1:0] xs;
    xs = signed'(x);
    if (sgn && xs < 0) return unsigned'(-xs);
    return x;
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic neg);
    logic signed [WIDTH-1:0] xs;
    xs = signed'(x);
    return neg ? unsigned'(-xs) : x;
  endfunction

  assign sgn_op  = SIGNED_EN && is_signed;
  assign shifted = {rem_r, quo_r[WIDTH-1]};
  // Top bit of the difference is the borrow: set exactly when shifted < divisor.
  assign diff    = shifted - {1'b0, dvsr_r};
  assign borrow  = diff[WIDTH];

  always_ff @(posedge clk) begin
    if (Clear) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      rem_r       <= '0;
      quo_r       <= '0;
      dvsr_r      <= '0;
      cnt_r       <= '0;
      q_neg_r     <= 1'b0;
      r_neg_r     <= 1'b0;
      dz_r        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            rem_r       <= '0;
            if (divisor == '0) begin
              // Raw dividend parked in quo_r so FIX can return it untouched.
              dz_r  <= 1'b1;
              quo_r <= dividend;
              state <= FIX;
            end else begin
              dz_r    <= 1'b0;
              quo_r   <= mag(dividend, sgn_op);
              dvsr_r  <= mag(divisor, sgn_op);
              q_neg_r <= sgn_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              r_neg_r <= sgn_op && dividend[WIDTH-1];
              cnt_r   <= CNT_W'(WIDTH);
              state   <= CALC;
            end
          end
        end
        CALC: begin
          rem_r <= borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
          quo_r <= {quo_r[WIDTH-2:0], ~borrow};
          cnt_r <= cnt_r - 1'b1;
          if (cnt_r == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          if (dz_r) begin
            quotient  <= '1;
            remainder <= quo_r;
          end else begin
            quotient  <= neg_if(quo_r, q_neg_r);
            remainder <= neg_if(rem_r, r_neg_r);
          end
          div_by_zero <= dz_r;
          busy        <= 1'b0;
          done        <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed testbench for seq_divider (WIDTH=32): hand-computed quotients, remainders,
// latencies, divide-by-zero, signed overflow and mid-operation Clear.
module tb_seq_divider;

  logic        clk;
  logic        clear;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;

  seq_divider #(.WIDTH(32), .SIGNED_EN(1'b1)) dut (
    .clk        (clk),
    .Clear      (clear),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Called just after a rising edge; accepts on the next edge and waits for done.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [31:0] exp_q, input logic [31:0] exp_r,
                         input logic exp_dz, input int exp_lat);
    int   lat;
    logic busy_ok;
    dividend  = a;
    divisor   = b;
    is_signed = sgn;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = 1'b0;
    busy_ok   = busy;
    lat       = 0;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (!done && !busy) busy_ok = 1'b0;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_held"}, {31'd0, busy_ok}, 32'd1);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_q"}, quotient, exp_q);
    check({tag, "_r"}, remainder, exp_r);
    check({tag, "_dz"}, {31'd0, div_by_zero}, {31'd0, exp_dz});
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic saw_done;
    clear     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    clear = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_dz", {31'd0, div_by_zero}, 32'd0);

    run_div("u30_25",    32'd30,        32'd25,        1'b0, 32'd1,        32'd5,        1'b0, 33);
    run_div("s_m30_7",   32'hFFFFFFE2,  32'h00000007,  1'b1, 32'hFFFFFFFC, 32'hFFFFFFFE, 1'b0, 33);
    run_div("s_30_m7",   32'd30,        32'hFFFFFFF9,  1'b1, 32'hFFFFFFFC, 32'h00000002, 1'b0, 33);
    run_div("u_ff_2",    32'hFFFFFFFF,  32'd2,         1'b0, 32'h7FFFFFFF, 32'd1,        1'b0, 33);
    run_div("s_m1_2",    32'hFFFFFFFF,  32'd2,         1'b1, 32'h00000000, 32'hFFFFFFFF, 1'b0, 33);
    run_div("dz_100",    32'd100,       32'd0,         1'b0, 32'hFFFFFFFF, 32'd100,      1'b1, 1);
    run_div("u9_3",      32'd9,         32'd3,         1'b0, 32'd3,        32'd0,        1'b0, 33);
    run_div("s_ovf",     32'h80000000,  32'hFFFFFFFF,  1'b1, 32'h80000000, 32'd0,        1'b0, 33);
    run_div("u_ff_1",    32'hFFFFFFFF,  32'd1,         1'b0, 32'hFFFFFFFF, 32'd0,        1'b0, 33);
    run_div("u7_9",      32'd7,         32'd9,         1'b0, 32'd0,        32'd7,        1'b0, 33);

    // Abort: 50/7 accepted, stray start mid-CALC, Clear after ten iterations.
    dividend = 32'd50; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    saw_done = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 3) begin
        dividend = 32'd9; divisor = 32'd3; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    start = 1'b0;
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_q", quotient, 32'd0);
    check("abort_r", remainder, 32'd0);
    check("abort_dz", {31'd0, div_by_zero}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    check("abort_no_done", {31'd0, saw_done}, 32'd0);

    run_div("u50_7", 32'd50, 32'd7, 1'b0, 32'd7, 32'd1, 1'b0, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Parametrised multi-cycle restoring divider. It is the successor to the single-shot DIV path on the datapath.
- Accepts a dividend/divisor pair with a start/busy/done handshake.
- Iterates one quotient bit per clock.
- Returns the quotient (the LO value) and the remainder (the HI value), with an optional signed mode and divide-by-zero reporting.
- Sits beside the ALU, feeding the HI/LO registers through the Z path under control-unit sequencing.

Parameters:
- WIDTH, 32, operand/result width in bits (min 4).
- SIGNED_EN, 1, 1 = honour is_signed; 0 = is_signed ignored, always unsigned.

Ports:
- clk  in  1  system clock, rising-edge.
- Clear  in  1  synchronous active-high reset.
- start  in  1  request; sampled only in IDLE.
- is_signed  in  1  two's-complement operation when 1 (and SIGNED_EN=1).
- dividend  in  WIDTH  numerator, sampled on the accepting edge.
- divisor  in  WIDTH  denominator, sampled on the accepting edge.
- busy  out  1  high from the accepting edge until done.
- done  out  1  one-cycle pulse; results valid from this cycle.
- quotient  out  WIDTH  result for LO.
- remainder  out  WIDTH  result for HI.
- div_by_zero  out  1  set with done when divisor was 0.

Behaviour:
- Reset: while Clear=1 at a rising edge, state→IDLE and all outputs (busy, done, quotient, remainder, div_by_zero) and internal counters/registers→0. Clear has priority over everything, including mid-operation. An aborted operation never produces done.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On an edge with start=1, latch the operands and signedness; busy←1.
  - divisor≠0: take magnitudes (|x| if signed), record quotient sign = sign(dividend) XOR sign(divisor) and remainder sign = sign(dividend). Clear the partial remainder, load the counter with WIDTH, go to CALC.
  - divisor=0: go to FIX with the div-by-zero flag set.
- CALC, one bit per edge:
  - Shift {rem, quo} left 1 (the MSB of quo enters rem), using a WIDTH+1-bit partial remainder.
  - If rem ≥ |divisor|: rem ← rem−|divisor| and the quotient LSB ← 1; else LSB ← 0.
  - Decrement the counter. After the WIDTH-th iteration, go to FIX.
- FIX, one edge:
  - Apply sign correction: negate the quotient if its sign=1; negate the remainder if its sign=1.
  - Write quotient/remainder/div_by_zero; go to DONE.
- DONE, one cycle: done=1, busy=0; go to IDLE on the next edge.
- Latency: start accepted at edge k → done=1 during the cycle after edge k+WIDTH+1 (k+1 for divide-by-zero) and drops after edge k+WIDTH+2.
- Back-to-back: start held high during DONE is not accepted. The next accept can occur on the edge leaving IDLE, i.e. at the earliest 1 cycle after done.
- start while busy or in DONE: ignored; the operand inputs are don't-care after the accepting edge.
- Results hold their last values until the FIX of the next operation; they are not cleared by a new start.
- Signed rules:
  - Quotient truncates toward zero; the remainder takes the dividend's sign, so dividend = q·divisor + r always holds.
  - Overflow MIN/−1: quotient = MIN (wraps), remainder = 0, div_by_zero=0.
- Divide by zero: quotient = all ones, remainder = dividend unchanged (raw bits, no sign fix), div_by_zero=1. The flag is cleared at the next accept.
- Unsigned mode (is_signed=0 or SIGNED_EN=0): operands are treated as magnitudes and no negation is applied.

Test Plan:
- Reset, then unsigned 30/25 with WIDTH=32 → done 33 cycles after the accept edge, quotient=1, remainder=5, div_by_zero=0. busy high throughout, done exactly one cycle.
- Signed −30/7 (0xFFFFFFE2 / 0x00000007) → quotient=0xFFFFFFFC (−4), remainder=0xFFFFFFFE (−2). Also signed 30/−7 → quotient=0xFFFFFFFC, remainder=0x00000002.
- Unsigned 0xFFFFFFFF/2 with is_signed=0 → quotient=0x7FFFFFFF, remainder=1. The same operands with is_signed=1 → quotient=0, remainder=0xFFFFFFFF.
- Divide by zero 100/0 → done one cycle after accept, quotient=0xFFFFFFFF, remainder=100, div_by_zero=1. A following 9/3 → quotient=3, remainder=0, div_by_zero=0.
- Signed overflow 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0, no div_by_zero.
- Start 50/7, pulse start with 9/3 mid-CALC (ignored), assert Clear at iteration 10 → no done, all outputs 0, IDLE. A fresh 50/7 → quotient=7, remainder=1.
